plab4_net_domain_slot_sched: RTL and testbench
==============================================

# plab4_net_domain_slot_sched

Time-division security-domain scheduler and terminal injection gate for the timing-channel-protected mesh router. It generates the one-hot `domain0`/`domain1` slot signals consumed by every protected router and sits directly upstream of the router's two per-domain terminal input ports (`in_*_ter_d0`, `in_*_ter_d1`). Each domain's terminal traffic is admitted only during that domain's own slot and only up to a fixed per-slot message budget. Cross-domain injection timing therefore carries no information.

## Interface
Parameters:
- `p_msg_nbits`, 41, net message width (`VC_NET_MSG_NBITS(32,3,3)`).
- `p_slot_cycles`, 8, cycles per active domain slot; must be at least 1.
- `p_dead_cycles`, 2, turnaround cycles after each slot in which no domain is active; must be at least 1.
- `p_budget`, 4, maximum messages accepted per domain per slot; must be at least 1.
- `p_cnt_nbits`, 4, width of the slot, dead and budget counters; must hold `max(p_slot_cycles, p_dead_cycles, p_budget)`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `domain0`  out  1  domain-0 slot active.
- `domain1`  out  1  domain-1 slot active.
- `src_val_d0` / `src_rdy_d0` / `src_msg_d0`  in/out/in  1/1/`p_msg_nbits`  domain-0 terminal source.
- `src_val_d1` / `src_rdy_d1` / `src_msg_d1`  in/out/in  1/1/`p_msg_nbits`  domain-1 terminal source.
- `ter_val_d0` / `ter_rdy_d0` / `ter_msg_d0`  out/in/out  1/1/`p_msg_nbits`  to router `in_*_ter_d0`.
- `ter_val_d1` / `ter_rdy_d1` / `ter_msg_d1`  out/in/out  1/1/`p_msg_nbits`  to router `in_*_ter_d1`.
- `slot_epoch`  out  8  count of completed D1 slots; wraps from 255 to 0.

## Operation
- FSM states: `S_D0`, `S_DEAD0`, `S_D1`, `S_DEAD1`.
- `slot_cnt` counts cycles within the current state and clears on every state change.
- Transitions:
  - `S_D0` → `S_DEAD0` when `slot_cnt == p_slot_cycles-1`.
  - `S_DEAD0` → `S_D1` when `slot_cnt == p_dead_cycles-1`.
  - `S_D1` → `S_DEAD1` when `slot_cnt == p_slot_cycles-1`.
  - `S_DEAD1` → `S_D0` when `slot_cnt == p_dead_cycles-1`.
- Domain outputs are decoded from the state register only:
  - `domain0 = (state == S_D0)`.
  - `domain1 = (state == S_D1)`.
  - The two are never both 1.
- Per-domain injection counter `inj_x` increments on each fire (`src_val_dx & src_rdy_dx`).
  - It clears on the cycle the FSM enters `S_Dx`.
  - It saturates at `p_budget`.
- Gate: `gate_x = domainx & (inj_x < p_budget) & reset`.
- Pass-through logic:
  - `ter_val_dx = src_val_dx & gate_x`.
  - `src_rdy_dx = ter_rdy_dx & gate_x`.
  - `ter_msg_dx = src_msg_dx`.
  - No storage; message bits pass through unchanged.
- Decisions in one domain never depend on the other domain's `src_*` or `ter_rdy_*` signals.
- `slot_epoch` increments on the `S_D1` → `S_DEAD1` transition.

## Timing
- Reset (asynchronous while `reset == 0`):
  - state = `S_D0`; `slot_cnt`, `inj_0`, `inj_1` and `slot_epoch` = 0.
  - Outputs during reset: `domain0 = 1`, `domain1 = 0`, all `ter_val_*` = 0, all `src_rdy_*` = 0.
- First cycle after reset release: domain 0 owns the slot with a full budget.
- Reset asserted mid-slot: the FSM returns to `S_D0` immediately; any partial budget is discarded.
- Injection path is combinational: zero-cycle latency from `src` to `ter`.
- A transfer fires only on a clock edge where val, rdy and gate are all 1.
- Slot-end boundary:
  - A fire on the last cycle of `S_Dx` counts.
  - On the next cycle `gate_x = 0` regardless of the budget left.
- Budget boundary: the `p_budget`-th fire in a slot drops `gate_x` on the following cycle. No further fires occur in that slot.
- Full period = `2*(p_slot_cycles + p_dead_cycles)`; it is 20 cycles at the defaults.
- A source holding `src_val` across a closed gate must keep its message stable. The block does not latch it.

## Configuration
- Macro: `PLAB4_NET_DOMAIN_SCHED_DEAD_EN`.
- Defined:
  - The dead states exist as described above.
  - Period = `2*(p_slot_cycles + p_dead_cycles)`.
- Undefined:
  - `S_DEAD0` and `S_DEAD1` are compiled out and `p_dead_cycles` is ignored.
  - `S_D0` → `S_D1` → `S_D0` directly; period = `2*p_slot_cycles`.
  - `slot_epoch` increments on the `S_D1` → `S_D0` transition.
  - The budget clearing and all other behaviour are unchanged.

## Test plan
All scenarios use the default parameters.
- Reset release, no traffic:
  - `domain0 = 1` for cycles 0–7, both domains 0 for cycles 8–9, `domain1 = 1` for cycles 10–17, both 0 for cycles 18–19.
  - `slot_epoch = 1` at cycle 18.
- `src_val_d0` held at 1 and `ter_rdy_d0 = 1` throughout:
  - Exactly 4 fires, at cycles 0–3.
  - `src_rdy_d0 = 0` for cycles 4–19; 4 more fires at cycles 20–23.
- `src_val_d1 = 1` from cycle 0:
  - No fire until cycle 10.
  - `ter_val_d1` never asserted during cycles 0–9 or 18–19.
- `ter_rdy_d0` toggled 1,0,1,0,… while `src_val_d0 = 1`:
  - Fires at cycles 0, 2, 4, 6 only.
  - Message bits equal on `src_msg_d0` and `ter_msg_d0` every cycle.
- Domain-1 backpressure held at 0 while domain 0 streams:
  - Domain-0 fire cycles are identical to the no-backpressure run.
  - Proves no cross-domain coupling.
- `reset` pulsed low at cycle 13 (inside `S_D1`):
  - `domain1` drops to 0 and `domain0` rises to 1 asynchronously; `ter_val_*` = 0 during reset.
  - After release the schedule restarts as in the first scenario, with `slot_epoch = 0`.

Source files
------------

// File: rtl/plab4_net_domain_slot_sched.sv
// rtl/plab4_net_domain_slot_sched.sv - time-division domain slot scheduler and terminal injection gate
// Optional turnaround (dead) slots: define PLAB4_NET_DOMAIN_SCHED_DEAD_EN.
module plab4_net_domain_slot_sched #(
    parameter int p_msg_nbits   = 41,
    parameter int p_slot_cycles = 8,
    parameter int p_dead_cycles = 2,
    parameter int p_budget      = 4,
    parameter int p_cnt_nbits   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   domain0,
    output logic                   domain1,
    input  logic                   src_val_d0,
    output logic                   src_rdy_d0,
    input  logic [p_msg_nbits-1:0] src_msg_d0,
    input  logic                   src_val_d1,
    output logic                   src_rdy_d1,
    input  logic [p_msg_nbits-1:0] src_msg_d1,
    output logic                   ter_val_d0,
    input  logic                   ter_rdy_d0,
    output logic [p_msg_nbits-1:0] ter_msg_d0,
    output logic                   ter_val_d1,
    input  logic                   ter_rdy_d1,
    output logic [p_msg_nbits-1:0] ter_msg_d1,
    output logic [7:0]             slot_epoch
);

    localparam logic [p_cnt_nbits-1:0] SLOT_LAST = p_cnt_nbits'(p_slot_cycles - 1);
    localparam logic [p_cnt_nbits-1:0] BUDGET    = p_cnt_nbits'(p_budget);

    generate
        if (p_slot_cycles < 1 || p_dead_cycles < 1 || p_budget < 1 ||
            p_slot_cycles >= (1 << p_cnt_nbits) || p_dead_cycles >= (1 << p_cnt_nbits) ||
            p_budget >= (1 << p_cnt_nbits)) begin : g_bad_params
            $error("plab4_net_domain_slot_sched: illegal parameter combination");
        end
    endgenerate

`ifdef PLAB4_NET_DOMAIN_SCHED_DEAD_EN
    localparam logic [p_cnt_nbits-1:0] DEAD_LAST = p_cnt_nbits'(p_dead_cycles - 1);
    typedef enum logic [1:0] {S_D0, S_DEAD0, S_D1, S_DEAD1} state_t;
`else
    typedef enum logic [0:0] {S_D0, S_D1} state_t;
`endif

    state_t                 state;
    state_t                 state_next;
    logic [p_cnt_nbits-1:0] slot_cnt;
    logic [p_cnt_nbits-1:0] inj_0;
    logic [p_cnt_nbits-1:0] inj_1;
    logic                   epoch_inc;
    logic                   enter_d0;
    logic                   enter_d1;
    logic                   gate_0;
    logic                   gate_1;
    logic                   fire_0;
    logic                   fire_1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_D0;
            slot_cnt   <= '0;
            slot_epoch <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) slot_cnt <= '0;
            else                     slot_cnt <= slot_cnt + 1'b1;
            if (epoch_inc) slot_epoch <= slot_epoch + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        epoch_inc  = 1'b0;
        case (state)
`ifdef PLAB4_NET_DOMAIN_SCHED_DEAD_EN
            S_D0:    if (slot_cnt == SLOT_LAST) state_next = S_DEAD0;
            S_DEAD0: if (slot_cnt == DEAD_LAST) state_next = S_D1;
            S_D1: begin
                if (slot_cnt == SLOT_LAST) begin
                    state_next = S_DEAD1;
                    epoch_inc  = 1'b1;
                end
            end
            S_DEAD1: if (slot_cnt == DEAD_LAST) state_next = S_D0;
`else
            S_D0:    if (slot_cnt == SLOT_LAST) state_next = S_D1;
            S_D1: begin
                if (slot_cnt == SLOT_LAST) begin
                    state_next = S_D0;
                    epoch_inc  = 1'b1;
                end
            end
`endif
            default: state_next = S_D0;
        endcase
    end

    assign domain0 = (state == S_D0);
    assign domain1 = (state == S_D1);

    assign enter_d0 = (state_next == S_D0) && (state != S_D0);
    assign enter_d1 = (state_next == S_D1) && (state != S_D1);

    // Gate also drops while reset is held so nothing leaks out during reset.
    assign gate_0 = domain0 && (inj_0 < BUDGET) && reset;
    assign gate_1 = domain1 && (inj_1 < BUDGET) && reset;

    assign ter_val_d0 = src_val_d0 & gate_0;
    assign src_rdy_d0 = ter_rdy_d0 & gate_0;
    assign ter_msg_d0 = src_msg_d0;
    assign ter_val_d1 = src_val_d1 & gate_1;
    assign src_rdy_d1 = ter_rdy_d1 & gate_1;
    assign ter_msg_d1 = src_msg_d1;

    assign fire_0 = src_val_d0 & src_rdy_d0;
    assign fire_1 = src_val_d1 & src_rdy_d1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inj_0 <= '0;
            inj_1 <= '0;
        end else begin
            if (enter_d0)                        inj_0 <= '0;
            else if (fire_0 && inj_0 != BUDGET)  inj_0 <= inj_0 + 1'b1;
            if (enter_d1)                        inj_1 <= '0;
            else if (fire_1 && inj_1 != BUDGET)  inj_1 <= inj_1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_plab4_net_domain_slot_sched.sv
// tb/tb_plab4_net_domain_slot_sched.sv - directed bench for plab4_net_domain_slot_sched
module tb_plab4_net_domain_slot_sched;

    localparam int S = 8;
    localparam int B = 4;
`ifdef PLAB4_NET_DOMAIN_SCHED_DEAD_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif
    localparam int P = 2 * (S + D);
    localparam int W = 41;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         domain0, domain1;
    logic         src_val_d0 = 1'b0, src_val_d1 = 1'b0;
    logic         src_rdy_d0, src_rdy_d1;
    logic [W-1:0] src_msg_d0 = '0, src_msg_d1 = '0;
    logic         ter_val_d0, ter_val_d1;
    logic         ter_rdy_d0 = 1'b0, ter_rdy_d1 = 1'b0;
    logic [W-1:0] ter_msg_d0, ter_msg_d1;
    logic [7:0]   slot_epoch;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] mask_a, mask_b;
    int          first1;

    always #5 clk = ~clk;

    plab4_net_domain_slot_sched dut (
        .clk        (clk),
        .reset      (reset),
        .domain0    (domain0),
        .domain1    (domain1),
        .src_val_d0 (src_val_d0),
        .src_rdy_d0 (src_rdy_d0),
        .src_msg_d0 (src_msg_d0),
        .src_val_d1 (src_val_d1),
        .src_rdy_d1 (src_rdy_d1),
        .src_msg_d1 (src_msg_d1),
        .ter_val_d0 (ter_val_d0),
        .ter_rdy_d0 (ter_rdy_d0),
        .ter_msg_d0 (ter_msg_d0),
        .ter_val_d1 (ter_val_d1),
        .ter_rdy_d1 (ter_rdy_d1),
        .ter_msg_d1 (ter_msg_d1),
        .slot_epoch (slot_epoch)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Hold reset with all handshakes asserted, check the gated outputs, release on a negedge.
    task automatic do_reset();
        reset      = 1'b0;
        src_val_d0 = 1'b1; src_val_d1 = 1'b1;
        ter_rdy_d0 = 1'b1; ter_rdy_d1 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_domain0", domain0, 1'b1);
        check("rst_domain1", domain1, 1'b0);
        check("rst_ter_val_d0", ter_val_d0, 1'b0);
        check("rst_ter_val_d1", ter_val_d1, 1'b0);
        check("rst_src_rdy_d0", src_rdy_d0, 1'b0);
        check("rst_src_rdy_d1", src_rdy_d1, 1'b0);
        check("rst_epoch", slot_epoch, 8'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // mode 0 idle, 1 d0 stream, 2 d1 stream, 3 d0 with toggling rdy, 4 d0 stream + d1 backpressured
    task automatic run_sched(input int ncyc, input int mode,
                             output logic [63:0] fire_mask0, output int first_fire1);
        int e0, e1;
        e0 = 0; e1 = 0;
        fire_mask0  = '0;
        first_fire1 = -1;
        for (int c = 0; c < ncyc; c++) begin
            int           ph;
            logic         ed0, ed1, g0, g1, v0, r0, v1, r1, f0, f1;
            logic [W-1:0] m0, m1;
            v0 = (mode == 1 || mode == 3 || mode == 4);
            r0 = (mode == 3) ? (c % 2 == 0) : (mode == 1 || mode == 4);
            v1 = (mode == 2 || mode == 4);
            r1 = (mode == 1 || mode == 2);
            m0 = W'({$urandom, $urandom});
            m1 = W'({$urandom, $urandom});
            src_val_d0 = v0; ter_rdy_d0 = r0; src_msg_d0 = m0;
            src_val_d1 = v1; ter_rdy_d1 = r1; src_msg_d1 = m1;
            #1;
            ph  = c % P;
            ed0 = (ph < S);
            ed1 = (ph >= S + D) && (ph < 2 * S + D);
            g0  = ed0 && (e0 < B);
            g1  = ed1 && (e1 < B);
            check("domain0", domain0, ed0);
            check("domain1", domain1, ed1);
            check("ter_val_d0", ter_val_d0, v0 & g0);
            check("src_rdy_d0", src_rdy_d0, r0 & g0);
            check("ter_val_d1", ter_val_d1, v1 & g1);
            check("src_rdy_d1", src_rdy_d1, r1 & g1);
            check("ter_msg_d0", ter_msg_d0, m0);
            check("ter_msg_d1", ter_msg_d1, m1);
            check("slot_epoch", slot_epoch, 8'(((c + D) / P) % 256));
            f0 = v0 & r0 & g0;
            f1 = v1 & r1 & g1;
            if (f0) begin
                e0++;
                if (c < 64) fire_mask0[c] = 1'b1;
            end
            if (f1) begin
                e1++;
                if (first_fire1 < 0) first_fire1 = c;
            end
            if ((c + 1) % P == 0)     e0 = 0;
            if ((c + 1) % P == S + D) e1 = 0;
            @(negedge clk);
        end
    endtask

    initial begin
        do_reset();
        run_sched(P + 4, 0, mask_a, first1);
        check("idle_no_fire", mask_a, 64'd0);

        do_reset();
        run_sched(24, 1, mask_a, first1);
        check("d0_stream_fires", mask_a, 64'hF | (64'hF << P));

        do_reset();
        run_sched(P, 2, mask_b, first1);
        check("d1_first_fire", first1, S + D);

        do_reset();
        run_sched(P, 3, mask_b, first1);
        check("d0_toggle_fires", mask_b, 64'h55);

        do_reset();
        run_sched(24, 4, mask_b, first1);
        check("d0_isolation", mask_b, mask_a);

        do_reset();
        run_sched(13, 0, mask_b, first1);
        src_val_d0 = 1'b1; src_val_d1 = 1'b1;
        ter_rdy_d0 = 1'b1; ter_rdy_d1 = 1'b1;
        #1;
        check("pre_rst_domain1", domain1, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_rst_domain0", domain0, 1'b1);
        check("mid_rst_domain1", domain1, 1'b0);
        check("mid_rst_ter_val_d0", ter_val_d0, 1'b0);
        check("mid_rst_ter_val_d1", ter_val_d1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        run_sched(P + 4, 0, mask_b, first1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
